// File: rtl/ov7670_sccb_config.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_sccb_config
// Description : Plays a fixed OV7670 register table over SCCB after START.
//               Optional NACK abort is enabled by defining SCCB_ACK_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ov7670_sccb_config #(
    parameter int         QUARTER_CYCLES = 64,
    parameter int         DELAY_CYCLES   = 250000,
    parameter logic [7:0] DEVICE_ID      = 8'h42
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       START,
    output logic       SIOC,
    output logic       SIOD_OUT,
    output logic       SIOD_OE,
    input  logic       SIOD_IN,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR,
    output logic [3:0] REG_INDEX
);

    localparam int              c_QW         = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
    localparam logic [c_QW-1:0] c_QLAST      = c_QW'(QUARTER_CYCLES - 1);
    localparam logic [17:0]     c_DLAST      = 18'(DELAY_CYCLES - 1);
    localparam logic [3:0]      c_LAST_ENTRY = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_SEND   = 3'd2,
        S_STOP   = 3'd3,
        S_GAP    = 3'd4,
        S_DELAY  = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    function automatic logic [15:0] f_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    f_entry = 16'h1280;
            4'd1:    f_entry = 16'hFF00;
            4'd2:    f_entry = 16'h120C;
            4'd3:    f_entry = 16'h40D0;
            4'd4:    f_entry = 16'h1140;
            4'd5:    f_entry = 16'h0C08;
            4'd6:    f_entry = 16'h140B;
            default: f_entry = 16'h1E00;
        endcase
    endfunction

    function automatic logic f_is_delay(input logic [3:0] idx);
        logic [15:0] e;
        e = f_entry(idx);
        f_is_delay = (e[15:8] == 8'hFF);
    endfunction

    state_t          state_q, state_d;
    logic [c_QW-1:0] qcyc_q, qcyc_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [4:0]      bit_q, bit_d;
    logic [17:0]     dcnt_q, dcnt_d;
    logic [3:0]      idx_q, idx_d;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic            nack_q, nack_d;
    logic            sioc_q, sioc_d, siod_q, siod_d, oe_q, oe_d;
    logic            w_qend, w_ackbit, w_advance;
    logic [15:0]     w_entry;
    logic [7:0]      w_byte;
    logic [3:0]      w_pos;

`ifndef SCCB_ACK_CHECK_EN
    logic unused_siod;
    assign unused_siod = SIOD_IN;
`endif

    assign w_qend   = (qcyc_q == c_QLAST);
    assign w_ackbit = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);

    always_comb begin
        state_d   = state_q;
        qcyc_d    = qcyc_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        dcnt_d    = dcnt_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        nack_d    = nack_q;
        w_advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    idx_d   = 4'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    nack_d  = 1'b0;
                    qcyc_d  = '0;
                    qtr_d   = 2'd0;
                    bit_d   = 5'd0;
                    dcnt_d  = 18'd0;
                    state_d = f_is_delay(4'd0) ? S_DELAY : S_START;
                end
            end
            S_START: begin
                qcyc_d = w_qend ? '0 : qcyc_q + 1'b1;
                if (w_qend) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd1) begin
                        state_d = S_SEND;
                        qtr_d   = 2'd0;
                        bit_d   = 5'd0;
                    end
                end
            end
            S_SEND: begin
                qcyc_d = w_qend ? '0 : qcyc_q + 1'b1;
`ifdef SCCB_ACK_CHECK_EN
                if (w_ackbit && qtr_q == 2'd2 && qcyc_q == '0) begin
                    nack_d = SIOD_IN;
                end
`endif
                if (w_qend) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        // A NACK cuts the write short right after its ack bit.
                        if (bit_q == 5'd26 || (nack_q && w_ackbit)) begin
                            state_d = S_STOP;
                            bit_d   = 5'd0;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end
            end
            S_STOP: begin
                qcyc_d = w_qend ? '0 : qcyc_q + 1'b1;
                if (w_qend) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd2) begin
                        qtr_d = 2'd0;
                        if (nack_q) begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                qcyc_d = w_qend ? '0 : qcyc_q + 1'b1;
                if (w_qend) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        w_advance = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                if (dcnt_q >= c_DLAST) begin
                    w_advance = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 18'd1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if (w_advance) begin
            qcyc_d = '0;
            qtr_d  = 2'd0;
            bit_d  = 5'd0;
            dcnt_d = 18'd0;
            if (idx_q == c_LAST_ENTRY) begin
                state_d = S_FINISH;
            end else begin
                idx_d   = idx_q + 4'd1;
                state_d = f_is_delay(idx_q + 4'd1) ? S_DELAY : S_START;
            end
        end
    end

    // Bus pins are decoded from the next state so they come straight off flops.
    always_comb begin
        w_entry = f_entry(idx_d);
        w_byte  = DEVICE_ID;
        w_pos   = bit_d[3:0];
        if (bit_d >= 5'd18) begin
            w_byte = w_entry[7:0];
            w_pos  = 4'(bit_d - 5'd18);
        end else if (bit_d >= 5'd9) begin
            w_byte = w_entry[15:8];
            w_pos  = 4'(bit_d - 5'd9);
        end
        sioc_d = 1'b1;
        siod_d = 1'b1;
        oe_d   = 1'b0;
        case (state_d)
            S_START: begin
                oe_d   = 1'b1;
                siod_d = 1'b0;
                sioc_d = (qtr_d == 2'd0);
            end
            S_SEND: begin
                sioc_d = qtr_d[1];
                if (w_pos != 4'd8) begin
                    oe_d   = 1'b1;
                    siod_d = w_byte[3'd7 - w_pos[2:0]];
                end
            end
            S_STOP: begin
                oe_d   = 1'b1;
                sioc_d = (qtr_d != 2'd0);
                siod_d = (qtr_d == 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            qcyc_q  <= '0;
            qtr_q   <= 2'd0;
            bit_q   <= 5'd0;
            dcnt_q  <= 18'd0;
            idx_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            nack_q  <= 1'b0;
            sioc_q  <= 1'b1;
            siod_q  <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            qcyc_q  <= qcyc_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            dcnt_q  <= dcnt_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            nack_q  <= nack_d;
            sioc_q  <= sioc_d;
            siod_q  <= siod_d;
            oe_q    <= oe_d;
        end
    end

    assign SIOC      = sioc_q;
    assign SIOD_OUT  = siod_q;
    assign SIOD_OE   = oe_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERROR     = err_q;
    assign REG_INDEX = idx_q;

endmodule
`default_nettype wire

// File: doc/ov7670_sccb_config.md
# ov7670_sccb_config

Sequences the OV7670 register setup over SCCB (a 3-wire I2C-like camera bus) from the 25 MHz domain. After a START pulse it plays a fixed internal table of register writes to the camera (device ID 0x42). The table selects RGB565 output and the scaled frame the capture path stores in M9K. The block raises DONE when the capture/VGA path may trust pixel data. It sits beside the capture logic and drives the camera's SIOC/SIOD pins on GPIO.

## Interface
Parameters:
- QUARTER_CYCLES, 64, CLOCK cycles per quarter SCCB bit period (bit rate = 25 MHz / (4·64) ≈ 98 kHz).
- DELAY_CYCLES, 250000, wait after a delay-table entry (10 ms at 25 MHz).
- DEVICE_ID, 8'h42, SCCB write address byte.

Ports:
- CLOCK  in  1  25 MHz system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begins the sequence from entry 0. Ignored while BUSY.
- SIOC  out  1  SCCB clock.
- SIOD_OUT  out  1  SCCB data value when driven.
- SIOD_OE  out  1  1 = drive SIOD_OUT onto the pin; 0 = release (pull-up).
- SIOD_IN  in  1  SCCB data pin readback.
- BUSY  out  1  high from the cycle after START until DONE or ERROR.
- DONE  out  1  level; high after the last entry completes; cleared by START or RESET.
- ERROR  out  1  level; NACK abort (see Configuration); cleared by START or RESET.
- REG_INDEX  out  4  table entry currently being processed.

## Operation
- Table, 8 entries of {sub-addr, data}:
  - 0: 12/80 (COM7 reset)
  - 1: FF/00 (delay marker)
  - 2: 12/0C (QCIF, RGB)
  - 3: 40/D0 (COM15 RGB565, full range)
  - 4: 11/40 (CLKRC, external clock direct)
  - 5: 0C/08 (COM3 scale enable)
  - 6: 14/0B (COM9)
  - 7: 1E/00 (MVFP)
- Sub-addr 0xFF is a delay entry: no bus activity; the block waits DELAY_CYCLES, then advances.
- States: IDLE → START_COND → SEND → STOP_COND → GAP → next entry (or DELAY → next entry); after entry 7, GAP → FINISH → IDLE with DONE=1.
- Write transaction, in quarters (Q = QUARTER_CYCLES cycles each):
  - START_COND, 2 quarters: (SIOC=1, SIOD=0), then (SIOC=0, SIOD=0).
  - SEND, 27 bits × 4 quarters: DEVICE_ID, sub-addr, data. Each byte is sent MSB first and followed by a 9th don't-care bit.
  - Per bit: SIOD changes only at quarter 0, with SIOC=0 in quarters 0–1 and SIOC=1 in quarters 2–3.
  - 9th bits: SIOD_OE=0.
  - STOP_COND, 3 quarters: (0,0), (1,0), (1,1).
  - GAP: 4 quarters idle (SIOC=1, SIOD released).
- Outside transactions: SIOC=1, SIOD_OE=0.
- Counters: quarter counter 0..Q−1; bit counter 0..26; delay counter 18 bits, saturating compare at DELAY_CYCLES−1; REG_INDEX 0..7, no wrap (FINISH at 7).
- RESET at any time: the next edge forces IDLE and releases the bus immediately, possibly truncating a transaction. The camera tolerates this; firmware reissues START.
- START and RESET in the same cycle: RESET wins.

## Timing
- Reset values: SIOC=1, SIOD_OUT=1, SIOD_OE=0, BUSY=0, DONE=0, ERROR=0, REG_INDEX=0.
- START sampled at edge n: BUSY=1, DONE=0, ERROR=0 at n+1. SIOD_OE=1 with SIOD_OUT=0 (start condition) also at n+1.
- One write = 117·Q cycles (7488 at defaults), START_COND through end of GAP.
- Full sequence = 7·117·Q + DELAY_CYCLES + 1 cycles from START to DONE (FINISH is 1 cycle).
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- SCCB_ACK_CHECK_EN defined:
  - SIOD_IN is sampled at the first cycle of quarter 2 of each 9th bit.
  - Sample = 1 (NACK): finish the current bit, emit STOP_COND, then set ERROR=1 and BUSY=0, go to IDLE, and leave REG_INDEX at the failing entry.
- Not defined: SIOD_IN is ignored (pure SCCB don't-care); ERROR is tied 0.

## Test plan
- Reset: hold RESET 3 cycles → SIOC=1, SIOD_OE=0, BUSY=0, DONE=0, REG_INDEX=0; START in the same cycle as RESET → no activity.
- Full sequence (Q=4, DELAY=100, SIOD_IN pulled 0):
  - START → BUSY next cycle.
  - Decoded bus bytes: 42 12 80, then 100-cycle gap with SIOC=1; 42 12 0C … 42 1E 00.
  - DONE after exactly 7·468+101 cycles.
- Bit timing: check SIOD only changes while SIOC=0; SIOC high for 2Q cycles per bit; SIOD_OE=0 on each 9th bit.
- START while BUSY: pulse mid-entry 3 → sequence unaffected, REG_INDEX continues 3→4.
- RESET mid-bit during entry 5 → bus released next cycle; a following START restarts from entry 0 (bytes 42 12 80).
- With SCCB_ACK_CHECK_EN, SIOD_IN=1 on the ack of entry 2's sub-addr → stop condition, ERROR=1, BUSY=0, REG_INDEX=2; without the macro → sequence completes, DONE=1.
